// File: rtl/lsu.sv
// lsu: load/store unit between the memory stage and a synchronous-read dmem.
// Byte-addressed requests, word-only dmem; sub-word stores are read-modify-write.
module lsu #(
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [1:0]               req_size,
  input  logic                     req_unsigned,
  input  logic [ADDRESS_WIDTH+1:0] req_addr,
  input  logic [32:0]              req_wdata,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [32:0]              resp_rdata,
  output logic                     resp_err,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [32:0]              mem_wdata,
  input  logic [32:0]              mem_rdata
);

  localparam int AW = ADDRESS_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DATA,
    RESP
  } state_t;

  state_t state;
  state_t state_nx;

  logic          r_we;
  logic [1:0]    r_size;
  logic          r_uns;
  logic [AW+1:0] r_addr;
  logic [32:0]   r_wdata;
  logic [32:0]   rdata_q;
  logic          err_q;

  logic          bad;
  logic          sz_b;
  logic          sz_h;
  logic          sz_w;
  logic          we_raw;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;
  logic [32:0]   load_val;
  logic [32:0]   merged;
  logic [4:0]    off_b;
  logic [4:0]    off_h;

  always_comb begin
    bad = 1'b0;
    unique case (req_size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = req_addr[0];
      2'b10:   bad = |req_addr[1:0];
      default: bad = 1'b1;
    endcase
  end

  assign sz_b  = (r_size == 2'b00);
  assign sz_h  = (r_size == 2'b01);
  assign sz_w  = (r_size == 2'b10);
  assign off_b = {r_addr[1:0], 3'b000};
  assign off_h = {r_addr[1], 4'b0000};

  always_comb begin
    lane_b   = mem_rdata[off_b +: 8];
    lane_h   = mem_rdata[off_h +: 16];
    load_val = mem_rdata;
    unique case (1'b1)
      sz_b: load_val = {1'b0, {24{lane_b[7] & ~r_uns}}, lane_b};
      sz_h: load_val = {1'b0, {16{lane_h[15] & ~r_uns}}, lane_h};
      default: load_val = mem_rdata;
    endcase
  end

  // sub-word writes always drop the tag
  always_comb begin
    merged = {1'b0, mem_rdata[31:0]};
    unique case (1'b1)
      sz_b: merged[off_b +: 8]  = r_wdata[7:0];
      sz_h: merged[off_h +: 16] = r_wdata[15:0];
      default: merged = {1'b0, mem_rdata[31:0]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    we_raw     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    unique case (state)
      IDLE: begin
        req_ready = !rst;
        if (req_valid && !rst)
          state_nx = bad ? RESP : ISSUE;
      end
      ISSUE: begin
        mem_addr = r_addr[AW+1:2];
        if (r_we && sz_w) begin
          we_raw    = 1'b1;
          mem_wdata = r_wdata;
          state_nx  = RESP;
        end else begin
          state_nx  = DATA;
        end
      end
      DATA: begin
        mem_addr = r_addr[AW+1:2];
        if (r_we) begin
          we_raw    = 1'b1;
          mem_wdata = merged;
        end
        state_nx = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign mem_we = we_raw && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_size  <= 2'b00;
      r_uns   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (req_valid && req_ready) begin
        r_we    <= req_we;
        r_size  <= req_size;
        r_uns   <= req_unsigned;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        rdata_q <= '0;
        err_q   <= bad;
      end
      if (state == DATA && !r_we)
        rdata_q <= load_val;
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: vector table plus hand sequences for the load/store unit.
// Includes a synchronous-read dmem model and a response scoreboard.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [9:0]  req_addr;
  logic [32:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [32:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [32:0] mem_wdata;
  logic [32:0] mem_rdata;

  lsu #(.ADDRESS_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [32:0] dm [256];
  int wcount = 0;

  always @(posedge clk) begin
    mem_rdata <= dm[mem_addr];
    if (mem_we) begin
      dm[mem_addr] <= mem_wdata;
      wcount <= wcount + 1;
    end
  end

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        un;
    logic [9:0]  addr;
    logic [32:0] wd;
    logic [32:0] rd;
    logic        err;
    int          lat;
    int          wr;
  } vec_t;

  typedef struct {
    logic [32:0] rd;
    logic        err;
    int          lat;
    int          wr;
  } exp_t;

  vec_t tv[$];
  exp_t sb[$];
  int total = 0;
  int bad = 0;

  function automatic vec_t mk(logic we, logic [1:0] sz, logic un,
                              logic [9:0] a, logic [32:0] wd,
                              logic [32:0] rd, logic err,
                              int lat, int wr);
    vec_t v;
    v.we = we; v.sz = sz; v.un = un; v.addr = a; v.wd = wd;
    v.rd = rd; v.err = err; v.lat = lat; v.wr = wr;
    return v;
  endfunction

  task automatic chk(string name, logic [32:0] act, logic [32:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(vec_t v);
    req_valid    = 1'b1;
    req_we       = v.we;
    req_size     = v.sz;
    req_unsigned = v.un;
    req_addr     = v.addr;
    req_wdata    = v.wd;
  endtask

  task automatic do_req(vec_t v, int idx);
    exp_t e;
    int lat;
    int w0;
    drive(v);
    chk($sformatf("req_ready[%0d]", idx), 33'(req_ready), 33'(1));
    w0 = wcount;
    tick();
    req_valid = 1'b0;
    e.rd = v.rd; e.err = v.err; e.lat = v.lat; e.wr = v.wr;
    sb.push_back(e);
    lat = 1;
    while (!resp_valid && lat < 20) begin
      tick();
      lat++;
    end
    e = sb.pop_front();
    if (!resp_valid) begin
      total++;
      bad++;
      $display("FAIL timeout[%0d] act=no_resp exp=resp", idx);
    end else begin
      chk($sformatf("rdata[%0d]", idx), resp_rdata, e.rd);
      chk($sformatf("err[%0d]", idx), 33'(resp_err), 33'(e.err));
      chk($sformatf("lat[%0d]", idx), 33'(lat), 33'(e.lat));
      chk($sformatf("writes[%0d]", idx), 33'(wcount - w0), 33'(e.wr));
    end
    tick();
  endtask

  initial begin
    rst = 1'b1; resp_ready = 1'b1; req_valid = 1'b0;
    req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;

    tv.push_back(mk(1, 2, 0, 10'h010, 33'h1_DEADBEEF, 33'h0, 0, 2, 1));
    tv.push_back(mk(0, 2, 0, 10'h010, 33'h0, 33'h1_DEADBEEF, 0, 3, 0));
    tv.push_back(mk(1, 0, 0, 10'h011, 33'h0_000000AB, 33'h0, 0, 3, 1));
    tv.push_back(mk(0, 2, 0, 10'h010, 33'h0, 33'h0_DEADABEF, 0, 3, 0));
    tv.push_back(mk(0, 0, 0, 10'h011, 33'h0, 33'h0_FFFFFFAB, 0, 3, 0));
    tv.push_back(mk(0, 0, 1, 10'h011, 33'h0, 33'h0_000000AB, 0, 3, 0));
    tv.push_back(mk(1, 2, 0, 10'h010, 33'h0_80011234, 33'h0, 0, 2, 1));
    tv.push_back(mk(0, 1, 0, 10'h012, 33'h0, 33'h0_FFFF8001, 0, 3, 0));
    tv.push_back(mk(0, 1, 1, 10'h012, 33'h0, 33'h0_00008001, 0, 3, 0));
    tv.push_back(mk(0, 1, 0, 10'h010, 33'h0, 33'h0_00001234, 0, 3, 0));
    tv.push_back(mk(1, 1, 0, 10'h012, 33'h0_00005678, 33'h0, 0, 3, 1));
    tv.push_back(mk(0, 2, 0, 10'h010, 33'h0, 33'h0_56781234, 0, 3, 0));
    tv.push_back(mk(0, 1, 0, 10'h013, 33'h0, 33'h0, 1, 1, 0));
    tv.push_back(mk(0, 2, 0, 10'h012, 33'h0, 33'h0, 1, 1, 0));
    tv.push_back(mk(0, 3, 0, 10'h010, 33'h0, 33'h0, 1, 1, 0));
    tv.push_back(mk(1, 1, 0, 10'h013, 33'h0_0000FFFF, 33'h0, 1, 1, 0));
    tv.push_back(mk(1, 2, 0, 10'h011, 33'h1_11111111, 33'h0, 1, 1, 0));
    tv.push_back(mk(1, 3, 0, 10'h010, 33'h1_22222222, 33'h0, 1, 1, 0));
    tv.push_back(mk(0, 2, 0, 10'h010, 33'h0, 33'h0_56781234, 0, 3, 0));
    tv.push_back(mk(0, 0, 0, 10'h013, 33'h0, 33'h0_00000056, 0, 3, 0));
    tv.push_back(mk(1, 2, 0, 10'h020, 33'h1_FFFFFFFF, 33'h0, 0, 2, 1));
    tv.push_back(mk(1, 0, 0, 10'h023, 33'h0_00000000, 33'h0, 0, 3, 1));
    tv.push_back(mk(0, 2, 0, 10'h020, 33'h0, 33'h0_00FFFFFF, 0, 3, 0));
    tv.push_back(mk(0, 0, 0, 10'h022, 33'h0, 33'h0_FFFFFFFF, 0, 3, 0));
    tv.push_back(mk(0, 0, 1, 10'h023, 33'h0, 33'h0_00000000, 0, 3, 0));

    tick();
    tick();
    chk("rst_req_ready", 33'(req_ready), 33'(0));
    chk("rst_resp_valid", 33'(resp_valid), 33'(0));
    chk("rst_resp_rdata", resp_rdata, 33'h0);
    chk("rst_resp_err", 33'(resp_err), 33'(0));
    chk("rst_mem_we", 33'(mem_we), 33'(0));
    chk("rst_mem_addr", 33'(mem_addr), 33'(0));
    chk("rst_mem_wdata", mem_wdata, 33'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 33'(req_ready), 33'(1));

    foreach (tv[i]) do_req(tv[i], i);
    chk("dm_word4", dm[4], 33'h0_56781234);

    // response stall: new request held pending the whole time
    resp_ready = 1'b0;
    drive(mk(0, 2, 0, 10'h010, 33'h0, 33'h0, 0, 0, 0));
    tick();
    drive(mk(0, 3, 0, 10'h010, 33'h0, 33'h0, 0, 0, 0));
    begin
      int n = 1;
      while (!resp_valid && n < 20) begin tick(); n++; end
      chk("stall_lat", 33'(n), 33'(3));
    end
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall_valid[%0d]", k), 33'(resp_valid), 33'(1));
      chk($sformatf("stall_rdata[%0d]", k), resp_rdata, 33'h0_56781234);
      chk($sformatf("stall_ready[%0d]", k), 33'(req_ready), 33'(0));
      chk($sformatf("stall_we[%0d]", k), 33'(mem_we), 33'(0));
      tick();
    end
    resp_ready = 1'b1;
    tick();
    chk("hs_req_ready", 33'(req_ready), 33'(1));
    tick();
    req_valid = 1'b0;
    chk("hs_err_valid", 33'(resp_valid), 33'(1));
    chk("hs_err", 33'(resp_err), 33'(1));
    chk("hs_err_rdata", resp_rdata, 33'h0);
    tick();

    // reset in DATA of a byte store
    drive(mk(1, 0, 0, 10'h010, 33'h0_000000EE, 33'h0, 0, 0, 0));
    tick();
    req_valid = 1'b0;
    tick();
    chk("data_we", 33'(mem_we), 33'(1));
    chk("data_addr", 33'(mem_addr), 33'(4));
    rst = 1'b1;
    #1;
    chk("data_we_gated", 33'(mem_we), 33'(0));
    tick();
    chk("mid_rst_ready", 33'(req_ready), 33'(0));
    chk("mid_rst_valid", 33'(resp_valid), 33'(0));
    chk("mid_rst_mem_addr", 33'(mem_addr), 33'(0));
    chk("mid_rst_dm4", dm[4], 33'h0_56781234);
    rst = 1'b0;
    #1;
    chk("after_rst_ready", 33'(req_ready), 33'(1));
    tick();
    chk("after_rst_noresp", 33'(resp_valid), 33'(0));
    do_req(mk(0, 2, 0, 10'h010, 33'h0, 33'h0_56781234, 0, 3, 0), 99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
